// File: rtl/mem_access_unit_if.sv
// Shared constants for the memory access unit, plus the pipeline/RAM bus
// interface the unit is connected through.
package mem_access_unit_pkg;
  localparam int EXCEPTION_LEN = 4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK               = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_LOAD_MISALIGNED  = 4'd4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_STORE_MISALIGNED = 4'd6;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;
endpackage

interface mem_access_unit_if;
  import mem_access_unit_pkg::*;
  logic                     reqValid_In;
  logic                     reqReady_Out;
  logic                     isLoad_In;
  logic [2:0]               funct3_In;
  logic [31:0]              addr_In;
  logic [31:0]              storeData_In;
  logic                     flush_In;
  logic [31:0]              ramAddr_Out;
  logic [31:0]              ramData_Out;
  logic [1:0]               ramWidth_Out;
  logic                     ramIsRead_Out;
  logic                     ramValid_Out;
  logic [31:0]              ramData_In;
  logic                     ramOK_In;
  logic [EXCEPTION_LEN-1:0] ramException_In;
  logic                     respValid_Out;
  logic [31:0]              loadData_Out;
  logic [EXCEPTION_LEN-1:0] exception_Out;

  // Unit side
  modport slave (
    input  reqValid_In, isLoad_In, funct3_In, addr_In, storeData_In, flush_In,
           ramData_In, ramOK_In, ramException_In,
    output reqReady_Out, ramAddr_Out, ramData_Out, ramWidth_Out, ramIsRead_Out,
           ramValid_Out, respValid_Out, loadData_Out, exception_Out
  );

  // Pipeline/RAM side
  modport master (
    output reqValid_In, isLoad_In, funct3_In, addr_In, storeData_In, flush_In,
           ramData_In, ramOK_In, ramException_In,
    input  reqReady_Out, ramAddr_Out, ramData_Out, ramWidth_Out, ramIsRead_Out,
           ramValid_Out, respValid_Out, loadData_Out, exception_Out
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: one outstanding RV32I load/store, legality and
// alignment checks, single-cycle RAM strobe, timeout, flush-drop response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   r_state, w_nxt;
  logic                     r_isLoad;
  logic [2:0]               r_funct3;
  logic [31:0]              r_addr, r_storeData;
  logic [EXCEPTION_LEN-1:0] r_exc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_drop;
  logic [31:0]              r_loadData;
  logic [EXCEPTION_LEN-1:0] r_excOut;

  logic                     w_accept, w_legal, w_misal, w_timeout;
  logic [EXCEPTION_LEN-1:0] w_reqExc, w_timeoutExc, w_finalExc;
  logic [31:0]              w_extData;

  assign w_accept  = bus.reqValid_In && (r_state == IDLE);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timeoutExc = r_isLoad ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;

  // Classify the incoming request: illegal encoding beats misalignment
  always_comb begin
    w_legal = 1'b0;
    if (bus.isLoad_In)
      w_legal = (bus.funct3_In inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      w_legal = (bus.funct3_In inside {3'b000, 3'b001, 3'b010});
    w_misal = ((bus.funct3_In[1:0] == 2'b01) && bus.addr_In[0]) ||
              ((bus.funct3_In[1:0] == 2'b10) && (bus.addr_In[1:0] != 2'b00));
    w_reqExc = EXCEP_OK;
    if (!w_legal)
      w_reqExc = bus.isLoad_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
    else if (w_misal)
      w_reqExc = bus.isLoad_In ? EXCEP_LOAD_MISALIGNED : EXCEP_STORE_MISALIGNED;
  end

  // Exception and load result as they will appear in the coming RESP;
  // RAM data is extended straight off the bus in the completing WAIT cycle
  always_comb begin
    w_finalExc = r_exc;
    if (r_state == IDLE)
      w_finalExc = w_reqExc;
    else if (r_state == WAIT && !bus.ramOK_In && r_exc == EXCEP_OK)
      w_finalExc = w_timeoutExc;
    case (r_funct3)
      3'b000:  w_extData = {{24{bus.ramData_In[7]}}, bus.ramData_In[7:0]};
      3'b001:  w_extData = {{16{bus.ramData_In[15]}}, bus.ramData_In[15:0]};
      3'b010:  w_extData = bus.ramData_In;
      3'b100:  w_extData = {24'd0, bus.ramData_In[7:0]};
      3'b101:  w_extData = {16'd0, bus.ramData_In[15:0]};
      default: w_extData = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_nxt = (w_reqExc != EXCEP_OK) ? RESP : ISSUE;
      ISSUE: w_nxt = WAIT;
      WAIT:  if (bus.ramOK_In || w_timeout) w_nxt = RESP;
      RESP:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; RAM fields only driven while issuing
  always_comb begin
    bus.reqReady_Out  = (r_state == IDLE);
    bus.ramValid_Out  = (r_state == ISSUE);
    bus.ramAddr_Out   = 32'd0;
    bus.ramData_Out   = 32'd0;
    bus.ramWidth_Out  = MEM_WIDTH_BYTE;
    bus.ramIsRead_Out = 1'b0;
    if (r_state == ISSUE) begin
      bus.ramAddr_Out   = r_addr;
      bus.ramIsRead_Out = r_isLoad;
      case (r_funct3[1:0])
        2'b00: begin
          bus.ramWidth_Out = MEM_WIDTH_BYTE;
          bus.ramData_Out  = {24'd0, r_storeData[7:0]};
        end
        2'b01: begin
          bus.ramWidth_Out = MEM_WIDTH_HALF;
          bus.ramData_Out  = {16'd0, r_storeData[15:0]};
        end
        default: begin
          bus.ramWidth_Out = MEM_WIDTH_WORD;
          bus.ramData_Out  = r_storeData;
        end
      endcase
    end
    // A flush arriving in RESP itself still kills the pulse
    bus.respValid_Out = (r_state == RESP) && !r_drop && !bus.flush_In;
    bus.loadData_Out  = r_loadData;
    bus.exception_Out = r_excOut;
  end

  // Request capture, exception tracking, WAIT counter and flush drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isLoad    <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_storeData <= 32'd0;
      r_exc       <= EXCEP_OK;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_isLoad    <= bus.isLoad_In;
        r_funct3    <= bus.funct3_In;
        r_addr      <= bus.addr_In;
        r_storeData <= bus.storeData_In;
        r_exc       <= w_reqExc;
      end
      if (r_state == ISSUE) begin
        r_exc <= bus.ramException_In;
        r_cnt <= '0;
      end
      if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state != IDLE && w_nxt == IDLE) r_drop <= 1'b0;
      else if (r_state != IDLE && bus.flush_In) r_drop <= 1'b1;
    end
  end

  // Response registers load on entry to RESP and hold until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loadData <= 32'd0;
      r_excOut   <= EXCEP_OK;
    end else if (r_state != RESP && w_nxt == RESP) begin
      r_excOut   <= w_finalExc;
      r_loadData <= (r_isLoad && r_state == WAIT && w_finalExc == EXCEP_OK) ? w_extData : 32'd0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   k;

  always #5 clk = ~clk;

  mem_access_unit_if bus();
  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive point
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    bus.reqValid_In  = 1'b1;
    bus.isLoad_In    = ld;
    bus.funct3_In    = f3;
    bus.addr_In      = a;
    bus.storeData_In = sd;
    smp();
    chk("accept_ready", {31'd0, bus.reqReady_Out}, 32'd1);
    nxt();
    bus.reqValid_In = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.reqValid_In = 0; bus.isLoad_In = 0; bus.funct3_In = 0; bus.addr_In = 0;
    bus.storeData_In = 0; bus.flush_In = 0; bus.ramData_In = 0; bus.ramOK_In = 0;
    bus.ramException_In = 0;
    smp();
    chk("rst_ready", {31'd0, bus.reqReady_Out}, 32'd1);
    chk("rst_ramvalid", {31'd0, bus.ramValid_Out}, 32'd0);
    chk("rst_resp", {31'd0, bus.respValid_Out}, 32'd0);
    chk("rst_exc", {28'd0, bus.exception_Out}, 32'd0);
    chk("rst_ldata", bus.loadData_Out, 32'd0);
    nxt(); rst = 1'b0;
    nxt();

    // LB 0x100, RAM returns 0x80
    req(1, 3'b000, 32'h100, 32'd0);
    smp();
    chk("lb_ramvalid", {31'd0, bus.ramValid_Out}, 32'd1);
    chk("lb_width", {30'd0, bus.ramWidth_Out}, 32'd0);
    chk("lb_addr", bus.ramAddr_Out, 32'h100);
    chk("lb_isread", {31'd0, bus.ramIsRead_Out}, 32'd1);
    chk("lb_busy", {31'd0, bus.reqReady_Out}, 32'd0);
    nxt(); bus.ramOK_In = 1; bus.ramData_In = 32'h80;
    smp();
    chk("lb_n2_ramvalid", {31'd0, bus.ramValid_Out}, 32'd0);
    chk("lb_n2_resp", {31'd0, bus.respValid_Out}, 32'd0);
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("lb_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("lb_ldata", bus.loadData_Out, 32'hFFFFFF80);
    chk("lb_exc", {28'd0, bus.exception_Out}, 32'd0);
    nxt(); smp();
    chk("lb_pulse_end", {31'd0, bus.respValid_Out}, 32'd0);
    chk("lb_idle", {31'd0, bus.reqReady_Out}, 32'd1);
    chk("lb_hold", bus.loadData_Out, 32'hFFFFFF80);
    nxt();

    // SH 0x202
    req(0, 3'b001, 32'h202, 32'hDEADBEEF);
    smp();
    chk("sh_ramvalid", {31'd0, bus.ramValid_Out}, 32'd1);
    chk("sh_data", bus.ramData_Out, 32'h0000BEEF);
    chk("sh_width", {30'd0, bus.ramWidth_Out}, 32'd1);
    chk("sh_isread", {31'd0, bus.ramIsRead_Out}, 32'd0);
    nxt(); bus.ramOK_In = 1;
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("sh_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("sh_exc", {28'd0, bus.exception_Out}, 32'd0);
    chk("sh_ldata", bus.loadData_Out, 32'd0);
    nxt();

    // LW misaligned 0x103
    req(1, 3'b010, 32'h103, 32'd0);
    smp();
    chk("lwmis_ramvalid", {31'd0, bus.ramValid_Out}, 32'd0);
    chk("lwmis_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("lwmis_exc", {28'd0, bus.exception_Out}, 32'd4);
    chk("lwmis_ldata", bus.loadData_Out, 32'd0);
    nxt();

    // SW misaligned 0x202
    req(0, 3'b010, 32'h202, 32'd0);
    smp();
    chk("swmis_exc", {28'd0, bus.exception_Out}, 32'd6);
    nxt();

    // Illegal load funct3 011 and store funct3 100
    req(1, 3'b011, 32'h100, 32'd0);
    smp();
    chk("ill_ld_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("ill_ld_exc", {28'd0, bus.exception_Out}, 32'd5);
    nxt();
    req(0, 3'b100, 32'h100, 32'd0);
    smp();
    chk("ill_st_ramvalid", {31'd0, bus.ramValid_Out}, 32'd0);
    chk("ill_st_exc", {28'd0, bus.exception_Out}, 32'd7);
    nxt();

    // SW with RAM exception flagged during ISSUE
    req(0, 3'b010, 32'h2000_0000, 32'h12345678);
    bus.ramException_In = 4'd7;
    smp();
    chk("swx_data", bus.ramData_Out, 32'h12345678);
    chk("swx_width", {30'd0, bus.ramWidth_Out}, 32'd2);
    nxt(); bus.ramException_In = 0; bus.ramOK_In = 1;
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("swx_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("swx_exc", {28'd0, bus.exception_Out}, 32'd7);
    nxt();

    // LW timeout: RESP 16 WAIT cycles after ISSUE
    req(1, 3'b010, 32'h300, 32'd0);
    smp();
    chk("to_ramvalid", {31'd0, bus.ramValid_Out}, 32'd1);
    k = 0;
    while (k < 40) begin
      nxt(); k++; smp();
      if (bus.respValid_Out) break;
    end
    chk("to_latency", k, 32'd17);
    chk("to_exc", {28'd0, bus.exception_Out}, 32'd5);
    chk("to_ldata", bus.loadData_Out, 32'd0);
    nxt(); bus.ramOK_In = 1; bus.ramData_In = 32'hAAAA5555;
    smp();
    chk("to_late_ok_resp", {31'd0, bus.respValid_Out}, 32'd0);
    chk("to_late_ok_ready", {31'd0, bus.reqReady_Out}, 32'd1);
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("to_late_ok_hold", {28'd0, bus.exception_Out}, 32'd5);
    nxt();

    // Flush in WAIT: no pulse, ready again at N+4
    req(1, 3'b010, 32'h104, 32'd0);
    nxt(); bus.flush_In = 1; bus.ramOK_In = 1; bus.ramData_In = 32'h1234;
    nxt(); bus.flush_In = 0; bus.ramOK_In = 0;
    smp();
    chk("fl_no_pulse", {31'd0, bus.respValid_Out}, 32'd0);
    nxt(); smp();
    chk("fl_ready_n4", {31'd0, bus.reqReady_Out}, 32'd1);
    // Flush in IDLE has no effect; LBU then gets its pulse
    bus.flush_In = 1;
    nxt(); bus.flush_In = 0;
    req(1, 3'b100, 32'h101, 32'd0);
    nxt(); bus.ramOK_In = 1; bus.ramData_In = 32'h0000_00FF;
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("lbu_resp", {31'd0, bus.respValid_Out}, 32'd1);
    chk("lbu_ldata", bus.loadData_Out, 32'h0000_00FF);
    nxt();

    // LH sign extension
    req(1, 3'b001, 32'h102, 32'd0);
    nxt(); bus.ramOK_In = 1; bus.ramData_In = 32'h0000_8001;
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("lh_ldata", bus.loadData_Out, 32'hFFFF8001);
    nxt();

    // LHU zero extension
    req(1, 3'b101, 32'h102, 32'd0);
    nxt(); bus.ramOK_In = 1; bus.ramData_In = 32'h0000_8001;
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("lhu_ldata", bus.loadData_Out, 32'h0000_8001);
    nxt();

    // Reset asserted in WAIT
    req(1, 3'b010, 32'h108, 32'd0);
    nxt();
    rst = 1'b1;
    #1;
    chk("rstw_ready", {31'd0, bus.reqReady_Out}, 32'd1);
    chk("rstw_ldata", bus.loadData_Out, 32'd0);
    chk("rstw_resp", {31'd0, bus.respValid_Out}, 32'd0);
    nxt(); rst = 1'b0; bus.ramOK_In = 1; bus.ramData_In = 32'h5A5A5A5A;
    smp();
    chk("rstw_late_ok", {31'd0, bus.respValid_Out}, 32'd0);
    nxt(); bus.ramOK_In = 0;
    smp();
    chk("rstw_no_pulse", {31'd0, bus.respValid_Out}, 32'd0);
    chk("rstw_idle", {31'd0, bus.reqReady_Out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
